alu_issue: RTL and testbench

Command-buffering issue stage that sits in front of the ALU datapath and produces the 3-bit `OP` word that the datapath control decoder consumes. It accepts (opcode, A, B) commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head command to the combinational ALU, then registers the ALU result together with its opcode into an output stage with its own valid/ready handshake. It is the producer end of the `OP` interface: the control decoder turns `OP` into datapath selects, and this block decides which `OP` is driven each cycle.

---
 rtl/alu_issue.sv | 112 +++++++++++
 tb/tb_alu_issue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: command FIFO feeding a combinational ALU,
// with a registered result stage on a valid/ready handshake.
module alu_issue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [2:0]               IN_OP,
   input  logic [WIDTH-1:0]         IN_A,
   input  logic [WIDTH-1:0]         IN_B,
   output logic [2:0]               OP,
   output logic [WIDTH-1:0]         A,
   output logic [WIDTH-1:0]         B,
   output logic                     ALU_VALID,
   input  logic [WIDTH-1:0]         R,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [2:0]               OUT_OP,
   output logic [WIDTH-1:0]         OUT_R,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [2:0]       op_mem [DEPTH];
   logic [WIDTH-1:0] a_mem  [DEPTH];
   logic [WIDTH-1:0] b_mem  [DEPTH];

   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic             out_valid;
   logic [2:0]       out_op;
   logic [WIDTH-1:0] out_r;

   logic             push;
   logic             pop;
   logic             issue;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign IN_READY = (count < FULL);
   assign push     = IN_VALID && IN_READY;
   assign issue    = (count != '0) && (!out_valid || OUT_READY);
   assign pop      = issue;

   assign ALU_VALID = issue;
   assign OUT_VALID = out_valid;
   assign OUT_OP    = out_op;
   assign OUT_R     = out_r;
   assign COUNT     = count;

   // Drive the head entry to the ALU only while it is being issued.
   always_comb begin
      OP = '0;
      A  = '0;
      B  = '0;
      if (issue) begin
         OP = op_mem[head];
         A  = a_mem[head];
         B  = b_mem[head];
      end
   end

   // Command storage; contents are don't-care until written.
   always_ff @(posedge CLK) begin
      if (push) begin
         op_mem[tail] <= IN_OP;
         a_mem[tail]  <= IN_A;
         b_mem[tail]  <= IN_B;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy tracked separately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Result stage: capture on issue, clear on a drain with nothing behind it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_r     <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         out_op    <= OP;
         out_r     <= R;
      end else if (out_valid && OUT_READY) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus for alu_issue,
// checked against a queue-based transaction model.
module tb_alu_issue;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [2:0] IN_OP = '0;
   logic [7:0] IN_A = '0;
   logic [7:0] IN_B = '0;
   logic [2:0] OP;
   logic [7:0] A;
   logic [7:0] B;
   logic       ALU_VALID;
   logic [7:0] R;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic [2:0] OUT_OP;
   logic [7:0] OUT_R;
   logic [2:0] COUNT;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   cmd_t       q[$];
   logic       m_ov = 1'b0;
   logic [2:0] m_op = '0;
   logic [7:0] m_r  = '0;

   alu_issue #(.WIDTH(8), .DEPTH(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B),
      .OP(OP), .A(A), .B(B), .ALU_VALID(ALU_VALID), .R(R),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_OP(OUT_OP), .OUT_R(OUT_R), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] alu(input logic [2:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ~a;
         3'd6: return a << 1;
         default: return b;
      endcase
   endfunction

   // Bench-side ALU responding to the driven OP/A/B.
   always_comb R = alu(OP, A, B);

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rst_chk();
      chk("rst_in_ready", 32'(IN_READY), 32'd1);
      chk("rst_alu_valid", 32'(ALU_VALID), 32'd0);
      chk("rst_op", 32'(OP), 32'd0);
      chk("rst_a", 32'(A), 32'd0);
      chk("rst_b", 32'(B), 32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_out_r", 32'(OUT_R), 32'd0);
      chk("rst_out_op", 32'(OUT_OP), 32'd0);
   endtask

   // One cycle: drive, compare against the model, advance the model.
   task automatic step(input logic v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
      logic       e_rdy;
      logic       e_av;
      logic [2:0] e_op;
      logic [7:0] e_a;
      logic [7:0] e_b;
      cmd_t       c;
      IN_VALID  = v;
      IN_OP     = op;
      IN_A      = a;
      IN_B      = b;
      OUT_READY = rdy;
      #1;
      e_rdy = (q.size() < 4);
      e_av  = (q.size() != 0) && (!m_ov || rdy);
      e_op  = e_av ? q[0].op : 3'd0;
      e_a   = e_av ? q[0].a : 8'd0;
      e_b   = e_av ? q[0].b : 8'd0;
      chk("in_ready", 32'(IN_READY), 32'(e_rdy));
      chk("count", 32'(COUNT), 32'(q.size()));
      chk("alu_valid", 32'(ALU_VALID), 32'(e_av));
      chk("op", 32'(OP), 32'(e_op));
      chk("a", 32'(A), 32'(e_a));
      chk("b", 32'(B), 32'(e_b));
      chk("out_valid", 32'(OUT_VALID), 32'(m_ov));
      chk("out_op", 32'(OUT_OP), 32'(m_op));
      chk("out_r", 32'(OUT_R), 32'(m_r));
      @(posedge CLK);
      if (e_av) begin
         c    = q.pop_front();
         m_r  = alu(c.op, c.a, c.b);
         m_op = c.op;
         m_ov = 1'b1;
      end else if (m_ov && rdy) begin
         m_ov = 1'b0;
      end
      if (v && e_rdy) begin
         c.op = op;
         c.a  = a;
         c.b  = b;
         q.push_back(c);
      end
      @(negedge CLK);
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      rst_chk();
      RST_N = 1'b1;
      @(negedge CLK);

      // Single command: 5 + 3.
      step(1'b1, 3'd0, 8'h05, 8'h03, 1'b1);
      chk("single_alu_valid", 32'(ALU_VALID), 32'd1);
      chk("single_op", 32'(OP), 32'd0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      chk("single_out_valid", 32'(OUT_VALID), 32'd1);
      chk("single_out_r", 32'(OUT_R), 32'h08);
      chk("single_out_op", 32'(OUT_OP), 32'd0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Full-rate stream.
      for (int i = 0; i < 16; i++)
         step(1'b1, 3'(i % 8), 8'(i), 8'd1, 1'b1);
      repeat (3) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Backpressure and fill, then release.
      for (int i = 0; i < 7; i++)
         step(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      chk("fill_in_ready", 32'(IN_READY), 32'd0);
      chk("fill_count", 32'(COUNT), 32'd4);
      repeat (7) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Hold occupancy at 3 with simultaneous push/pop.
      for (int i = 0; i < 4; i++)
         step(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      chk("wrap_count", 32'(COUNT), 32'd3);
      chk("wrap_out_valid", 32'(OUT_VALID), 32'd1);

      // Asynchronous reset mid-stream.
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      #2;
      RST_N = 1'b0;
      #1;
      rst_chk();
      q.delete();
      m_ov = 1'b0;
      m_op = '0;
      m_r  = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      step(1'b1, 3'd4, 8'h5a, 8'h0f, 1'b1);
      repeat (4) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Drain with nothing queued.
      step(1'b1, 3'd1, 8'h40, 8'h01, 1'b0);
      repeat (2) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      chk("drain_out_valid", 32'(OUT_VALID), 32'd0);
      chk("drain_out_r", 32'(OUT_R), 32'h3f);
      chk("drain_alu_valid", 32'(ALU_VALID), 32'd0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

      // Random traffic.
      for (int i = 0; i < 300; i++)
         step(1'($urandom), 3'($urandom), 8'($urandom),
              8'($urandom), 1'($urandom));
      repeat (8) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
